// File: rtl/prbs8_checker.sv
// Receive-side checker for the X^8+X^6+X^5+X^4+1 PRBS stream: self-sync, lock, error count.
// Optional self-test input inject_err is enabled with `define PRBS8_CHK_INJECT_EN.
module prbs8_checker #(
  parameter int LOCK_COUNT  = 16,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_cnt,
`ifdef PRBS8_CHK_INJECT_EN
  input  logic             inject_err,
`endif
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam int WE_W = $clog2(LOSS_THRESH + 1);
  localparam logic [MC_W-1:0] LOCK_LAST = MC_W'(LOCK_COUNT - 1);
  localparam logic [WE_W-1:0] LOSS_T    = WE_W'(LOSS_THRESH);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          st;
  logic [1:8]      sr;
  logic [2:0]      fill_cnt;
  logic [MC_W-1:0] match_cnt;
  logic [4:0]      win_cnt;
  logic [WE_W-1:0] win_err;

  logic            rx_bit;
  logic            pred;
  logic            err_hit;
  logic [WE_W-1:0] win_err_nxt;

`ifdef PRBS8_CHK_INJECT_EN
  assign rx_bit = bit_in ^ (inject_err & bit_valid);
`else
  assign rx_bit = bit_in;
`endif

  assign pred        = sr[8] ^ sr[6] ^ sr[5] ^ sr[4];
  assign err_hit     = (rx_bit != pred);
  assign win_err_nxt = win_err + WE_W'(1);
  assign state       = st;

  always_ff @(posedge clock) begin
    if (reset) begin
      st        <= FILL;
      sr        <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (clear_cnt) err_count <= '0;
      if (bit_valid) begin
        case (st)
          FILL: begin
            sr <= {rx_bit, sr[1:7]};
            if (fill_cnt == 3'd7) begin
              st        <= VERIFY;
              fill_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 3'd1;
            end
          end
          VERIFY: begin
            sr <= {rx_bit, sr[1:7]};
            // an all-zero register predicts zeros forever, so it never earns lock
            if (!err_hit && (sr != '0)) begin
              if (match_cnt == LOCK_LAST) begin
                st        <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
                win_cnt   <= '0;
                win_err   <= '0;
              end else begin
                match_cnt <= match_cnt + MC_W'(1);
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // free-running local copy: a line error does not pollute the predictor
            sr      <= {pred, sr[1:7]};
            win_cnt <= win_cnt + 5'd1;
            if (err_hit) begin
              err_pulse <= 1'b1;
              if (!clear_cnt && (err_count != '1)) err_count <= err_count + ERR_W'(1);
              if (win_err_nxt >= LOSS_T) begin
                st        <= FILL;
                locked    <= 1'b0;
                fill_cnt  <= '0;
                match_cnt <= '0;
                win_err   <= '0;
              end else if (win_cnt == 5'd31) begin
                win_err <= '0;
              end else begin
                win_err <= win_err_nxt;
              end
            end else if (win_cnt == 5'd31) begin
              win_err <= '0;
            end
          end
          default: st <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs8_checker.sv
// Bench for prbs8_checker: directed PRBS streams against a history-queue model of the checker.
module tb_prbs8_checker;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic clear_cnt = 1'b0;
`ifdef PRBS8_CHK_INJECT_EN
  logic inject_err = 1'b0;
`endif

  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic [1:0]  state;
  logic        locked2, err_pulse2;
  logic [1:0]  err_count2;
  logic [1:0]  state2;

  always #5 clock = ~clock;

  prbs8_checker dut (
    .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear_cnt(clear_cnt),
`ifdef PRBS8_CHK_INJECT_EN
    .inject_err(inject_err),
`endif
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .state(state)
  );

  // narrow counter instance to exercise saturation
  prbs8_checker #(.ERR_W(2)) dut_w2 (
    .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear_cnt(clear_cnt),
`ifdef PRBS8_CHK_INJECT_EN
    .inject_err(inject_err),
`endif
    .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2), .state(state2)
  );

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;
  bit lock_seen = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: mode 0/1/2 = filling, verifying, locked; hist holds the last 8 shifted bits, oldest first
  int m_mode, m_fill, m_match, m_nlock, m_werr, m_cnt, m_cnt2;
  bit m_pulse;
  bit hist[$];

  initial begin
    hist = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    m_mode = 0; m_fill = 0; m_match = 0; m_nlock = 0; m_werr = 0; m_cnt = 0; m_cnt2 = 0; m_pulse = 0;
  end

  function automatic void push(input bit b);
    hist.push_back(b);
    void'(hist.pop_front());
  endfunction

  always @(posedge clock) begin
    bit eff, p, z;
    if (reset) begin
      m_mode = 0; m_fill = 0; m_match = 0; m_nlock = 0; m_werr = 0;
      m_cnt = 0; m_cnt2 = 0; m_pulse = 0;
      hist = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    end else begin
      m_pulse = 0;
      if (clear_cnt) begin m_cnt = 0; m_cnt2 = 0; end
      if (bit_valid) begin
`ifdef PRBS8_CHK_INJECT_EN
        eff = bit_in ^ inject_err;
`else
        eff = bit_in;
`endif
        p = hist[0] ^ hist[2] ^ hist[3] ^ hist[4];
        z = 1;
        foreach (hist[i]) if (hist[i]) z = 0;
        if (m_mode == 0) begin
          push(eff);
          m_fill++;
          if (m_fill == 8) begin m_mode = 1; m_match = 0; end
        end else if (m_mode == 1) begin
          if (eff == p && !z) m_match++; else m_match = 0;
          push(eff);
          if (m_match == 16) begin m_mode = 2; m_nlock = 0; m_werr = 0; end
        end else begin
          push(p);
          m_nlock++;
          if (eff != p) begin
            m_pulse = 1;
            if (!clear_cnt) begin
              if (m_cnt < 65535) m_cnt++;
              if (m_cnt2 < 3) m_cnt2++;
            end
            m_werr++;
            if (m_werr >= 4) begin m_mode = 0; m_fill = 0; end
          end
          if (m_mode == 2 && (m_nlock % 32) == 0) m_werr = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("locked", int'(locked), int'(m_mode == 2));
      chk("state", int'(state), m_mode);
      chk("err_pulse", int'(err_pulse), int'(m_pulse));
      chk("err_count", int'(err_count), m_cnt);
      chk("err_count_w2", int'(err_count2), m_cnt2);
      chk("locked_w2", int'(locked2), int'(m_mode == 2));
    end
    if (err_pulse) pulse_cnt++;
    if (locked) lock_seen = 1;
  end

  // generator: same polynomial, fed-back bit is the transmitted bit
  bit gq[$];
  task automatic gen_seed();
    gq = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  endtask
  function automatic bit gen_next();
    bit b;
    b = gq[0] ^ gq[2] ^ gq[3] ^ gq[4];
    gq.push_back(b);
    void'(gq.pop_front());
    return b;
  endfunction

  task automatic send(input bit b, input bit v, input bit clr, input bit inj);
    @(negedge clock);
    reset = 1'b0;
    bit_valid = v;
    clear_cnt = clr;
`ifdef PRBS8_CHK_INJECT_EN
    bit_in = b;
    inject_err = inj;
`else
    bit_in = b ^ inj;
`endif
    @(posedge clock);
    #1;
  endtask

  task automatic rst();
    @(negedge clock);
    reset = 1'b1;
    bit_valid = 1'b1;
    clear_cnt = 1'b0;
    bit_in = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic lock_up();
    for (int i = 0; i < 24; i++) send(gen_next(), 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] first;
    int acc, iter;
    bit b;

    rst();
    cmp_en = 1;
    chk("reset_state", int'(state), 0);
    chk("reset_count", int'(err_count), 0);

    // lock acquisition from the documented seed
    gen_seed();
    first = '0;
    for (int i = 0; i < 8; i++) begin
      b = gen_next();
      first = {first[6:0], b};
      send(b, 1'b1, 1'b0, 1'b0);
    end
    chk("gen_first_byte", int'(first), 8'h64);
    chk("fill_to_verify", int'(state), 1);
    for (int i = 0; i < 15; i++) send(gen_next(), 1'b1, 1'b0, 1'b0);
    chk("not_locked_at_23", int'(locked), 0);
    send(gen_next(), 1'b1, 1'b0, 1'b0);
    chk("locked_at_24", int'(locked), 1);
    chk("state_locked", int'(state), 2);
    pulse_cnt = 0;
    for (int i = 0; i < 1000; i++) send(gen_next(), 1'b1, 1'b0, 1'b0);
    chk("clean_pulses", pulse_cnt, 0);
    chk("clean_count", int'(err_count), 0);

    // single error
    pulse_cnt = 0;
    send(gen_next(), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++) send(gen_next(), 1'b1, 1'b0, 1'b0);
    chk("single_pulses", pulse_cnt, 1);
    chk("single_count", int'(err_count), 1);
    chk("single_locked", int'(locked), 1);

    // burst of 4 errors inside one window
    rst();
    lock_up();
    send(gen_next(), 1'b1, 1'b0, 1'b0);
    send(gen_next(), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send(gen_next(), 1'b1, 1'b0, (i % 5) == 0);
      if (i == 10) chk("burst_3_still_locked", int'(locked), 1);
    end
    chk("burst_lost_lock", int'(locked), 0);
    chk("burst_state_fill", int'(state), 0);
    chk("burst_count", int'(err_count), 4);
    chk("burst_count_w2_sat", int'(err_count2), 3);
    for (int i = 0; i < 23; i++) send(gen_next(), 1'b1, 1'b0, 1'b0);
    chk("relock_not_at_23", int'(locked), 0);
    send(gen_next(), 1'b1, 1'b0, 1'b0);
    chk("relock_at_24", int'(locked), 1);
    chk("relock_count_held", int'(err_count), 4);

    // all-zero stream
    rst();
    lock_seen = 0;
    for (int i = 0; i < 8; i++) send(1'b0, 1'b1, 1'b0, 1'b0);
    chk("zero_state_verify", int'(state), 1);
    for (int i = 0; i < 192; i++) send(1'b0, 1'b1, 1'b0, 1'b0);
    chk("zero_state_end", int'(state), 1);
    chk("zero_never_locked", int'(lock_seen), 0);

    // valid gaps
    rst();
    gen_seed();
    acc = 0;
    iter = 0;
    while (acc < 24 && iter < 2000) begin
      iter++;
      if ($urandom_range(0, 1) == 1) begin
        send(gen_next(), 1'b1, 1'b0, 1'b0);
        acc++;
        if (acc == 23) chk("gaps_not_locked_23", int'(locked), 0);
        if (acc == 24) chk("gaps_locked_24", int'(locked), 1);
      end else begin
        send(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      end
    end
    chk("gaps_accepted_bound", acc, 24);
    for (int i = 0; i < 40; i++) send(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
    chk("gaps_hold_locked", int'(locked), 1);
    chk("gaps_hold_count", int'(err_count), 0);

    // clear priority, then reset while locked
    rst();
    lock_up();
    for (int k = 0; k < 5; k++) begin
      send(gen_next(), 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 39; i++) send(gen_next(), 1'b1, 1'b0, 1'b0);
    end
    chk("five_errors_count", int'(err_count), 5);
    chk("five_errors_w2_sat", int'(err_count2), 3);
    chk("five_errors_locked", int'(locked), 1);
    send(gen_next(), 1'b1, 1'b1, 1'b1);
    chk("clear_prio_count", int'(err_count), 0);
    chk("clear_prio_pulse", int'(err_pulse), 1);
    send(gen_next(), 1'b1, 1'b0, 1'b0);
    rst();
    chk("rst_locked", int'(locked), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_pulse", int'(err_pulse), 0);
    chk("rst_count", int'(err_count), 0);
    send(1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
